// File: rtl/wave_mixer_pkg.sv
// Shared definitions for the waveform mixer: mode codes, FSM states and
// the index-width helper used to size the channel counter.
package wave_mixer_pkg;

    localparam logic MODE_SAT = 1'b0;
    localparam logic MODE_AVG = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_NORM  = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // A single-channel mixer still needs a 1-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wave_mixer_add_sub_n.sv
// Ripple-carry adder/subtractor: sum = a + b when sub=0, a - b when sub=1
// (b is inverted and the carry-in set to form the two's complement).
module add_sub_n #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic carry;
    logic bx;

    always_comb begin
        sum   = '0;
        carry = sub;
        bx    = 1'b0;
        for (int unsigned i = 0; i < W; i++) begin
            bx     = b[i] ^ sub;
            sum[i] = a[i] ^ bx ^ carry;
            carry  = (a[i] & bx) | (carry & (a[i] ^ bx));
        end
    end

endmodule

// File: rtl/wave_mixer.sv
// N-channel signed mixer: accepts a frame, accumulates one channel per clock
// with per-channel add/subtract, then saturates or averages to WIDTH bits.
module wave_mixer
    import wave_mixer_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [CHANNELS*WIDTH-1:0]    in_samples,
    input  logic [CHANNELS-1:0]          in_sub,
    input  logic                         in_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_sample,
    output logic                         out_sat,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int SHIFT = $clog2(CHANNELS);
    localparam int ACC_W = WIDTH + SHIFT + 1;
    localparam int IDX_W = int'(idx_width(CHANNELS));

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(CHANNELS - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'((1 <<< (WIDTH - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

    state_t                      state;
    logic [CHANNELS*WIDTH-1:0]   samples_q;
    logic [CHANNELS-1:0]         sub_q;
    logic                        mode_q;
    logic signed [ACC_W-1:0]     acc;
    logic [IDX_W-1:0]            idx;

    logic [WIDTH-1:0]            cur_sample;
    logic [ACC_W-1:0]            sample_ext;
    logic [ACC_W-1:0]            acc_next;
    logic signed [ACC_W-1:0]     norm_v;
    logic [WIDTH-1:0]            clamped;
    logic                        clamp_hit;

    always_comb begin
        cur_sample = samples_q[int'(idx)*WIDTH +: WIDTH];
        sample_ext = {{(ACC_W - WIDTH){cur_sample[WIDTH-1]}}, cur_sample};
    end

    add_sub_n #(.W(ACC_W)) u_acc (
        .a   (acc),
        .b   (sample_ext),
        .sub (sub_q[idx]),
        .sum (acc_next)
    );

    // Averaging divides by 2^SHIFT (floor), so non-power-of-two channel
    // counts are scaled down by the next power of two, not by CHANNELS.
    always_comb begin
        norm_v    = (mode_q == MODE_AVG) ? (acc >>> SHIFT) : acc;
        clamped   = norm_v[WIDTH-1:0];
        clamp_hit = 1'b0;
        if (norm_v > SAT_HI) begin
            clamped   = SAT_HI[WIDTH-1:0];
            clamp_hit = 1'b1;
        end else if (norm_v < SAT_LO) begin
            clamped   = SAT_LO[WIDTH-1:0];
            clamp_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            samples_q  <= '0;
            sub_q      <= '0;
            mode_q     <= MODE_SAT;
            acc        <= '0;
            idx        <= '0;
            out_sample <= '0;
            out_sat    <= 1'b0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        samples_q <= in_samples;
                        sub_q     <= in_sub;
                        mode_q    <= in_mode;
                        acc       <= '0;
                        idx       <= '0;
                        in_ready  <= 1'b0;
                        state     <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    acc <= acc_next;
                    if (idx == LAST_IDX) begin
                        state <= ST_NORM;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_NORM: begin
                    out_sample <= clamped;
                    out_sat    <= clamp_hit;
                    out_valid  <= 1'b1;
                    state      <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wave_mixer.sv
// Scoreboard bench for wave_mixer (WIDTH=8, CHANNELS=4): stimulus queues the
// hand-computed result on frame acceptance, a monitor checks each handshake.
module tb_wave_mixer;

    localparam int WIDTH    = 8;
    localparam int CHANNELS = 4;
    localparam int LAT      = CHANNELS + 1;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS*WIDTH-1:0] in_samples;
    logic [CHANNELS-1:0]       in_sub;
    logic                      in_mode;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          out_sample;
    logic                      out_sat;
    logic                      out_valid;
    logic                      out_ready;

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             sat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;

    wave_mixer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_samples (in_samples),
        .in_sub     (in_sub),
        .in_mode    (in_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sample (out_sample),
        .out_sat    (out_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_output: got %0d with nothing expected", $signed(out_sample));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_sample", int'($signed(out_sample)), int'($signed(e.s)));
                chk("out_sat", int'(out_sat), int'(e.sat));
            end
        end
    end

    // Offers a frame, queues its expected result on acceptance, then waits
    // until out_valid is visible and checks the accept-to-valid latency.
    task automatic send(input int c0, input int c1, input int c2, input int c3,
                        input logic [3:0] sub, input logic mode,
                        input int es, input logic esat);
        int   n;
        exp_t e;
        in_samples = {8'(c3), 8'(c2), 8'(c1), 8'(c0)};
        in_sub     = sub;
        in_mode    = mode;
        in_valid   = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) chk("accept_timeout", n, 0);
        tick();
        in_valid = 1'b0;
        e.s   = es[WIDTH-1:0];
        e.sat = esat;
        sb.push_back(e);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("latency", n, LAT);
    endtask

    task automatic drain();
        tick();
        chk("out_valid_dropped", int'(out_valid), 0);
        chk("in_ready_back", int'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        in_samples = '0;
        in_sub     = '0;
        in_mode    = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_sample", int'(out_sample), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        reset = 1'b0;
        tick();
        chk("rst_in_ready", int'(in_ready), 1);

        send(10, 20, 30, 40, 4'b0000, 1'b0, 100, 1'b0);
        drain();
        send(100, 100, 100, -50, 4'b0000, 1'b0, 127, 1'b1);
        drain();
        send(-128, -128, -128, -128, 4'b0000, 1'b0, -128, 1'b1);
        drain();
        send(-128, 0, 0, 0, 4'b0001, 1'b0, 127, 1'b1);
        drain();
        send(50, 10, 20, 5, 4'b0101, 1'b0, -55, 1'b0);
        drain();

        send(127, 127, 127, 127, 4'b0000, 1'b1, 127, 1'b0);
        drain();
        send(-1, 0, 0, 0, 4'b0000, 1'b1, -1, 1'b0);
        drain();
        send(-128, 0, 0, 0, 4'b0001, 1'b1, 32, 1'b0);
        drain();

        // Consumer stall: result must hold and a new frame must wait.
        out_ready = 1'b0;
        send(1, -2, 3, -4, 4'b0000, 1'b0, -2, 1'b0);
        in_samples = {8'(-40), 8'(40), 8'(40), 8'(40)};
        in_sub     = 4'b1000;
        in_mode    = 1'b1;
        in_valid   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_sample", int'($signed(out_sample)), -2);
            chk("stall_sat", int'(out_sat), 0);
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        send(40, 40, 40, -40, 4'b1000, 1'b1, 40, 1'b0);
        drain();

        // Reset on the second accumulate cycle discards the frame.
        in_samples = {8'(100), 8'(100), 8'(100), 8'(100)};
        in_sub     = 4'b0000;
        in_mode    = 1'b0;
        in_valid   = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("abort_accepted", int'(in_ready), 0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin
                tick();
                if (out_valid) seen++;
            end
            chk("abort_no_output", seen, 0);
        end
        send(1, 2, 3, 4, 4'b0000, 1'b0, 10, 1'b0);
        drain();

        tick();
        tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
